// File: rtl/pipeline_cmd_pkg.sv
// pipeline_cmd_pkg: opcodes, need-flag bit positions, FSM states and field sizing
// shared by the pipeline command decoder.
package pipeline_cmd_pkg;
    localparam logic [7:0] OP_WRITE_BLOCK_INSTR = 8'h90;
    localparam logic [7:0] OP_WRITE_BLOCK_REG   = 8'hE0;
    localparam logic [7:0] OP_UPDATE_BLOCK_REG  = 8'hE1;
    localparam logic [7:0] OP_ALLOC_SRAM_DELAY  = 8'hA0;
    localparam logic [7:0] OP_RESET_BLOCK       = 8'h80;
    localparam logic [7:0] OP_NOP               = 8'h00;
    localparam int NEED_BLOCK = 7;
    localparam int NEED_REG   = 6;
    localparam int NEED_DATA  = 5;
    localparam int NEED_INSTR = 4;
    typedef enum logic [1:0] {IDLE, FIELD, CHECK, EXEC} state_t;
    function automatic int field_bytes(input int width);
        return width <= 8 ? 1 : (width + 7) / 8;
    endfunction
    function automatic logic valid_opcode(input logic [7:0] op);
        return op inside {OP_WRITE_BLOCK_INSTR, OP_WRITE_BLOCK_REG, OP_UPDATE_BLOCK_REG,
                          OP_ALLOC_SRAM_DELAY, OP_RESET_BLOCK, OP_NOP};
    endfunction
endpackage

// File: rtl/pipeline_command_decoder_if.sv
// pipeline_command_decoder_if: FIFO byte stream, exec handshake and decoded action outputs.
interface pipeline_command_decoder_if #(
    parameter int N_BLOCKS     = 256,
    parameter int N_BLOCK_REGS = 16,
    parameter int DATA_WIDTH   = 24,
    parameter int INSTR_WIDTH  = 32
);
    localparam int BW = $clog2(N_BLOCKS);
    localparam int RW = $clog2(N_BLOCK_REGS);
    logic [7:0] inp_byte;
    logic inp_valid, inp_read, exec_ready, busy;
    logic [BW-1:0] block_target;
    logic [RW-1:0] reg_target;
    logic [DATA_WIDTH-1:0] data_out;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic block_instr_write, block_reg_write, block_reg_update, alloc_sram_delay, block_reset;
    logic err_invalid, err_timeout, err_checksum;
    modport master (
        output inp_byte, inp_valid, exec_ready,
        input  inp_read, busy, block_target, reg_target, data_out, instr_out,
        input  block_instr_write, block_reg_write, block_reg_update, alloc_sram_delay, block_reset,
        input  err_invalid, err_timeout, err_checksum
    );
    modport slave (
        input  inp_byte, inp_valid, exec_ready,
        output inp_read, busy, block_target, reg_target, data_out, instr_out,
        output block_instr_write, block_reg_write, block_reg_update, alloc_sram_delay, block_reset,
        output err_invalid, err_timeout, err_checksum
    );
endinterface

// File: rtl/pipeline_cmd_timeout.sv
// pipeline_cmd_timeout: down-counter reloaded with CYCLES on load; expire marks the
// CYCLES-th enabled cycle since the last load.
module pipeline_cmd_timeout #(
    parameter int CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(CYCLES + 1);
    logic [W-1:0] cnt;
    assign expire = en && cnt == W'(1);
    always_ff @(posedge clk) begin
        if (reset || load) cnt <= W'(CYCLES);
        else if (en && cnt != '0) cnt <= cnt - W'(1);
    end
endmodule

// File: rtl/pipeline_command_decoder.sv
// pipeline_command_decoder: pops opcode + big-endian operand bytes from a FWFT FIFO and issues
// one strobed action per command. Define PIPELINE_CMD_CHECKSUM_EN to require a trailing XOR byte.
module pipeline_command_decoder
    import pipeline_cmd_pkg::*;
#(
    parameter int N_BLOCKS       = 256,
    parameter int N_BLOCK_REGS   = 16,
    parameter int DATA_WIDTH     = 24,
    parameter int INSTR_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic clk,
    input logic reset,
    pipeline_command_decoder_if.slave bus
);
    localparam int BW = $clog2(N_BLOCKS);
    localparam int RW = $clog2(N_BLOCK_REGS);
    localparam int BB = field_bytes(BW);
    localparam int RB = field_bytes(RW);
    localparam int DB = field_bytes(DATA_WIDTH);
    localparam int IB = field_bytes(INSTR_WIDTH);
`ifdef PIPELINE_CMD_CHECKSUM_EN
    localparam state_t DONE = CHECK;
`else
    localparam state_t DONE = EXEC;
`endif
    state_t state, state_n;
    logic [7:0] opcode, bcnt, fld_last;
    logic [3:0] rem;
    logic [1:0] fld;
    logic consume, expire, field_done, fields_done, fire;
    logic [BW-1:0] sh_block;
    logic [RW-1:0] sh_reg;
    logic [DATA_WIDTH-1:0] sh_data;
    logic [INSTR_WIDTH-1:0] sh_instr;
    assign bus.inp_read = !reset && state != EXEC;
    assign bus.busy = state != IDLE;
    assign consume = bus.inp_valid && bus.inp_read;
    assign fire = state == EXEC && bus.exec_ready;
    // rem holds still-needed fields with bit 0 = block; its lowest set bit is the field in flight
    assign fld = rem[0] ? 2'd0 : rem[1] ? 2'd1 : rem[2] ? 2'd2 : 2'd3;
    assign fld_last = 8'(fld == 2'd0 ? BB : fld == 2'd1 ? RB : fld == 2'd2 ? DB : IB) - 8'd1;
    assign field_done = bcnt == fld_last;
    assign fields_done = field_done && (rem & (rem - 4'd1)) == 4'd0;

    pipeline_cmd_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk),
        .reset(reset),
        .load(consume || !(state inside {FIELD, CHECK})),
        .en(state inside {FIELD, CHECK} && !bus.inp_valid),
        .expire(expire)
    );

`ifdef PIPELINE_CMD_CHECKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
            bus.err_checksum <= 1'b0;
        end else begin
            csum <= state == IDLE ? bus.inp_byte : consume ? csum ^ bus.inp_byte : csum;
            bus.err_checksum <= state == CHECK && consume && csum != bus.inp_byte;
        end
    end
`else
    assign bus.err_checksum = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (consume && valid_opcode(bus.inp_byte)) state_n = bus.inp_byte[7:4] == 4'd0 ? DONE : FIELD;
            FIELD: if (expire) state_n = IDLE; else if (consume && fields_done) state_n = DONE;
`ifdef PIPELINE_CMD_CHECKSUM_EN
            CHECK: if (expire) state_n = IDLE; else if (consume) state_n = csum == bus.inp_byte ? EXEC : IDLE;
`endif
            EXEC:  if (bus.exec_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            opcode <= '0;
            rem <= '0;
            bcnt <= '0;
            sh_block <= '0;
            sh_reg <= '0;
            sh_data <= '0;
            sh_instr <= '0;
            bus.block_target <= '0;
            bus.reg_target <= '0;
            bus.data_out <= '0;
            bus.instr_out <= '0;
            bus.block_instr_write <= 1'b0;
            bus.block_reg_write <= 1'b0;
            bus.block_reg_update <= 1'b0;
            bus.alloc_sram_delay <= 1'b0;
            bus.block_reset <= 1'b0;
            bus.err_invalid <= 1'b0;
            bus.err_timeout <= 1'b0;
        end else begin
            state <= state_n;
            bus.err_invalid <= state == IDLE && consume && !valid_opcode(bus.inp_byte);
            bus.err_timeout <= expire;
            bus.block_instr_write <= fire && opcode == OP_WRITE_BLOCK_INSTR;
            bus.block_reg_write <= fire && opcode == OP_WRITE_BLOCK_REG;
            bus.block_reg_update <= fire && opcode == OP_UPDATE_BLOCK_REG;
            bus.alloc_sram_delay <= fire && opcode == OP_ALLOC_SRAM_DELAY;
            bus.block_reset <= fire && opcode == OP_RESET_BLOCK;
            if (state == IDLE && consume) begin
                opcode <= bus.inp_byte;
                rem <= {bus.inp_byte[NEED_INSTR], bus.inp_byte[NEED_DATA], bus.inp_byte[NEED_REG], bus.inp_byte[NEED_BLOCK]};
                bcnt <= '0;
                sh_block <= '0;
                sh_reg <= '0;
                sh_data <= '0;
                sh_instr <= '0;
            end
            if (state == FIELD && consume) begin
                bcnt <= field_done ? 8'd0 : bcnt + 8'd1;
                rem <= field_done ? rem & (rem - 4'd1) : rem;
                if (fld == 2'd0) sh_block <= BW'({sh_block, bus.inp_byte});
                if (fld == 2'd1) sh_reg <= RW'({sh_reg, bus.inp_byte});
                if (fld == 2'd2) sh_data <= DATA_WIDTH'({sh_data, bus.inp_byte});
                if (fld == 2'd3) sh_instr <= INSTR_WIDTH'({sh_instr, bus.inp_byte});
            end
            if (fire) begin
                if (opcode[NEED_BLOCK]) bus.block_target <= sh_block;
                if (opcode[NEED_REG]) bus.reg_target <= sh_reg;
                if (opcode[NEED_DATA]) bus.data_out <= sh_data;
                if (opcode[NEED_INSTR]) bus.instr_out <= sh_instr;
            end
        end
    end
endmodule
